// File: rtl/cpu_defs.sv
// Shared definitions for the single-cycle MIPS datapath: next-PC selects,
// fetch FSM states and the opcodes the control unit keys on.
package cpu_defs;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam int ACK_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, region jump
// or register target, plus the misalignment indication for register targets.
module npc_calc
    import cpu_defs::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] ir,
    input  logic [31:0] rs_data,
    input  logic [1:0]  next_pc_sel,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] br_offset;
    logic [31:0] jump_target;
    logic        unused_opcode;

    assign br_offset     = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign unused_opcode = &{1'b0, ir[31:26]};

    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        case (next_pc_sel)
            NPC_SEQ: next_pc = pc_plus4;
            NPC_BR:  next_pc = pc_plus4 + br_offset;
            NPC_J:   next_pc = jump_target;
            NPC_JR: begin
                // Low bits are forced to zero; the caller records the fault.
                next_pc  = {rs_data[31:2], 2'b00};
                misalign = |rs_data[1:0];
            end
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC and IR registers, req/ack fetch FSM, ack timeout
// watchdog and decoded instruction fields for the control unit.
module instr_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    input  logic [1:0]  next_pc_sel,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err,
    output logic        imem_timeout
);

    localparam logic [ACK_CNT_W-1:0] ACK_LIMIT = ACK_CNT_W'(ACK_TIMEOUT);

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic [31:0]          ir;
    logic [31:0]          next_pc;
    logic                 jr_misalign;
    logic [ACK_CNT_W-1:0] wait_cnt;
    logic                 retire;

    assign retire = (state == S_HOLD) && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    npc_calc u_npc_calc (
        .pc_plus4    (pc_plus4),
        .ir          (ir),
        .rs_data     (rs_data),
        .next_pc_sel (next_pc_sel),
        .next_pc     (next_pc),
        .misalign    (jr_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            ir           <= 32'h0000_0000;
            wait_cnt     <= '0;
            misalign_err <= 1'b0;
            imem_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: wait_cnt <= '0;
                S_REQ: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                    end else if (wait_cnt != ACK_LIMIT) begin
                        // Counter saturates at the limit; the request stays up.
                        wait_cnt <= wait_cnt + 1'b1;
                        if ((wait_cnt + 1'b1) == ACK_LIMIT) begin
                            imem_timeout <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (retire) begin
                        pc       <= next_pc;
                        wait_cnt <= '0;
                        if (jr_misalign) begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign imm    = ir[15:0];
    assign funct  = ir[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed and randomized fetches
// compared against an instruction-level model of PC, IR and the sticky flags.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          ACK_TO   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [1:0]  next_pc_sel;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;
    logic        imem_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_mis;
    logic        m_to;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .funct        (funct),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm          (imm),
        .next_pc_sel  (next_pc_sel),
        .rs_data      (rs_data),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err),
        .imem_timeout (imem_timeout)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction-level next-PC rule, written as plain address arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] instr,
                                               input logic [31:0] rsd, input logic [1:0] sel);
        logic [31:0] p4;
        longint      off;
        p4 = cur_pc + 32'd4;
        case (sel)
            2'd0:    return p4;
            2'd1: begin
                off = longint'($signed(instr[15:0])) * 4;
                return p4 + off[31:0];
            end
            2'd2:    return (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
            default: return rsd & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic check_decode();
        check("opcode", opcode, m_ir >> 26);
        check("rs", rs, (m_ir >> 21) & 32'h1F);
        check("rt", rt, (m_ir >> 16) & 32'h1F);
        check("rd", rd, (m_ir >> 11) & 32'h1F);
        check("imm", imm, m_ir & 32'hFFFF);
        check("funct", funct, m_ir & 32'h3F);
    endtask

    task automatic check_flags();
        check("misalign_err", misalign_err, m_mis);
        check("imem_timeout", imem_timeout, m_to);
    endtask

    task automatic check_req();
        check("req_imem_req", imem_req, 1);
        check("req_valid", instr_valid, 0);
        check("req_addr", imem_addr, m_pc);
        check("req_pc", pc, m_pc);
        check("req_pc_plus4", pc_plus4, m_pc + 32'd4);
        check_flags();
    endtask

    task automatic check_hold();
        check("hold_valid", instr_valid, 1);
        check("hold_imem_req", imem_req, 0);
        check("hold_pc", pc, m_pc);
        check("hold_pc_plus4", pc_plus4, m_pc + 32'd4);
        check_decode();
        check_flags();
    endtask

    // Called at a falling edge with the DUT in the request phase.
    task automatic fetch_to_hold(input int ack_delay, input logic [31:0] instr);
        int waited;
        waited = 0;
        for (int i = 0; i < ack_delay; i++) begin
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom);
            next_pc_sel = 2'($urandom);
            rs_data     = $urandom;
            step();
            waited++;
            if (waited >= ACK_TO) m_to = 1'b1;
            check("wait_imem_req", imem_req, 1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_valid", instr_valid, 0);
            check("wait_timeout", imem_timeout, m_to);
        end
        imem_ack    = 1'b1;
        imem_rdata  = instr;
        instr_ready = 1'($urandom);
        step();
        imem_ack    = 1'b0;
        imem_rdata  = $urandom;
        instr_ready = 1'b0;
        m_ir        = instr;
        check_hold();
    endtask

    task automatic release_instr(input int ready_delay, input logic [1:0] sel, input logic [31:0] rsd);
        for (int i = 0; i < ready_delay; i++) begin
            instr_ready = 1'b0;
            next_pc_sel = 2'($urandom);
            rs_data     = $urandom;
            step();
            check_hold();
        end
        instr_ready = 1'b1;
        next_pc_sel = sel;
        rs_data     = rsd;
        step();
        instr_ready = 1'b0;
        next_pc_sel = 2'($urandom);
        rs_data     = $urandom;
        if (sel == 2'd3 && (rsd % 4) != 0) m_mis = 1'b1;
        m_pc = model_next(m_pc, m_ir, rsd, sel);
        check_req();
    endtask

    initial begin
        logic [1:0] rsel;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        next_pc_sel = 2'd0;
        rs_data     = 32'h0;
        m_pc        = RESET_PC;
        m_ir        = 32'h0;
        m_mis       = 1'b0;
        m_to        = 1'b0;
        repeat (3) step();

        $display("[TB] reset state");
        check("rst_imem_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc", pc, RESET_PC);
        check_decode();
        check_flags();

        rst         = 1'b0;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check_req();

        $display("[TB] first fetch and sequential stream");
        fetch_to_hold(0, 32'h0123_0020);
        check("tp_opcode", opcode, 0);
        check("tp_funct", funct, 32'h20);
        check("tp_rs", rs, 9);
        check("tp_rt", rt, 3);
        check("tp_pc", pc, 0);
        release_instr(0, 2'd0, $urandom);
        check("seq_addr4", imem_addr, 32'h4);
        fetch_to_hold(0, $urandom);
        release_instr(0, 2'd0, $urandom);
        check("seq_addr8", imem_addr, 32'h8);

        $display("[TB] branch, jump and wrap");
        fetch_to_hold(0, $urandom);
        release_instr(0, 2'd3, 32'h0000_0040);
        fetch_to_hold(1, 32'h1000_FFFE);
        release_instr(1, 2'd1, $urandom);
        check("br_addr", imem_addr, 32'h0000_003C);
        fetch_to_hold(0, $urandom);
        release_instr(0, 2'd3, 32'h1000_0000);
        fetch_to_hold(0, 32'h0800_0010);
        release_instr(0, 2'd2, $urandom);
        check("j_addr", imem_addr, 32'h1000_0040);
        fetch_to_hold(0, $urandom);
        release_instr(0, 2'd3, 32'hFFFF_FFFC);
        fetch_to_hold(0, $urandom);
        release_instr(0, 2'd0, $urandom);
        check("wrap_addr", imem_addr, 32'h0);
        check("mis_before", misalign_err, 0);

        $display("[TB] misaligned register target");
        fetch_to_hold(0, $urandom);
        release_instr(0, 2'd3, 32'h0000_0103);
        check("jr_addr", imem_addr, 32'h0000_0100);
        check("mis_set", misalign_err, 1);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 24; n++) begin
            rsel = 2'($urandom);
            fetch_to_hold(int'($urandom_range(0, 3)), $urandom);
            release_instr(int'($urandom_range(0, 2)), rsel, $urandom);
        end

        $display("[TB] ack timeout");
        check("to_before", imem_timeout, 0);
        fetch_to_hold(300, $urandom);
        check("to_after", imem_timeout, 1);
        release_instr(0, 2'd0, $urandom);

        $display("[TB] reset during hold");
        fetch_to_hold(0, $urandom);
        rst         = 1'b1;
        instr_ready = 1'b1;
        next_pc_sel = 2'd1;
        rs_data     = $urandom;
        step();
        rst         = 1'b0;
        instr_ready = 1'b0;
        m_pc        = RESET_PC;
        m_ir        = 32'h0;
        m_mis       = 1'b0;
        m_to        = 1'b0;
        check("hr_valid", instr_valid, 0);
        check("hr_imem_req", imem_req, 0);
        check("hr_pc", pc, RESET_PC);
        check_decode();
        check_flags();
        step();
        check_req();
        fetch_to_hold(0, $urandom);
        release_instr(0, 2'd0, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
